// File: rtl/irq_ctrl.sv
// Interrupt controller on the 5-bit CSR bus: per-source edge/level, polarity, enable and sticky pending.
// Optional build macro IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser on every src bit.
module irq_ctrl #(
    parameter logic [4:0]  BASE_ADDR   = 5'h00,
    parameter int          NUM_SOURCES = 8,
    parameter logic [15:0] DFL_MODE    = 16'hffff,
    parameter logic [15:0] DFL_POL     = 16'hffff
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             csr_a,
    input  logic [7:0]             csr_di,
    input  logic                   csr_we,
    output logic [7:0]             csr_do,
    input  logic [NUM_SOURCES-1:0] src,
    output logic                   irq_out
);

    localparam int          NUM_BANKS = (NUM_SOURCES + 7) / 8;
    localparam logic [5:0]  SPAN      = 6'(4 * NUM_BANKS);
    localparam logic [16:0] ONE_SH    = 17'h1 << NUM_SOURCES;
    // Implemented-source mask; wraps to 16'hffff when all 16 sources exist.
    localparam logic [15:0] VALID     = ONE_SH[15:0] - 16'h1;

    logic [15:0] pending_q, pending_d;
    logic [15:0] enable_q,  enable_d;
    logic [15:0] mode_q,    mode_d;
    logic [15:0] pol_q,     pol_d;
    logic [15:0] prev_q,    prev_d;
    logic        armed_q,   armed_d;
    logic        irq_out_q, irq_out_d;

    logic [15:0] src_ext;
    logic [15:0] s;
    logic [5:0]  off;
    logic        sel;
    logic        bank;
    logic [1:0]  kind;
    logic [15:0] wvec;
    logic [15:0] bmask;
    logic [15:0] rd_vec;
    logic [15:0] edge_v;
    logic [15:0] clr;
    logic [15:0] edge_pend;
    logic [15:0] level_pend;

    always_comb begin
        src_ext = '0;
        src_ext[NUM_SOURCES-1:0] = src;
    end

`ifdef IRQ_CTRL_SYNC_EN
    logic [15:0] sync1_q, sync1_d;
    logic [15:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = src_ext & VALID;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = src_ext & VALID;
`endif

    // Address decode; offset is computed one bit wider so addresses below BASE_ADDR cannot alias.
    always_comb begin
        off   = {1'b0, csr_a} - {1'b0, BASE_ADDR};
        sel   = (csr_a >= BASE_ADDR) && (off < SPAN);
        bank  = off[2];
        kind  = off[1:0];
        wvec  = bank ? {csr_di, 8'h00} : {8'h00, csr_di};
        bmask = bank ? 16'hff00 : 16'h00ff;
    end

    always_comb begin
        rd_vec = '0;
        case (kind)
            2'd0:    rd_vec = pending_q;
            2'd1:    rd_vec = enable_q;
            2'd2:    rd_vec = mode_q;
            default: rd_vec = pol_q;
        endcase
        csr_do = 8'h00;
        if (sel) begin
            csr_do = bank ? rd_vec[15:8] : rd_vec[7:0];
        end
    end

    // prev holds the raw sample, so a POL change alone never looks like an edge.
    always_comb begin
        edge_v     = armed_q ? ((pol_q & s & ~prev_q) | (~pol_q & ~s & prev_q)) : '0;
        clr        = (csr_we && sel && kind == 2'd0) ? wvec : '0;
        edge_pend  = edge_v | (pending_q & ~clr);
        level_pend = ~(s ^ pol_q);
        pending_d  = ((mode_q & edge_pend) | (~mode_q & level_pend)) & VALID;

        enable_d = enable_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        if (csr_we && sel) begin
            case (kind)
                2'd1:    enable_d = ((enable_q & ~bmask) | wvec) & VALID;
                2'd2:    mode_d   = ((mode_q   & ~bmask) | wvec) & VALID;
                2'd3:    pol_d    = ((pol_q    & ~bmask) | wvec) & VALID;
                default: ;
            endcase
        end

        prev_d    = s;
        armed_d   = 1'b1;
        irq_out_d = |(pending_q & enable_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= DFL_MODE & VALID;
            pol_q     <= DFL_POL & VALID;
            prev_q    <= '0;
            armed_q   <= 1'b0;
            irq_out_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pol_q     <= pol_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            irq_out_q <= irq_out_d;
        end
    end

    assign irq_out = irq_out_q;

endmodule
